mem_bus_ctrl: RTL

// - Next-generation data-memory subsystem for the single-cycle/multi-cycle computer top: sits between CPU load/store port and on-chip data RAM.
// - Adds req/ready handshake with configurable wait states, DMType byte/half/word access, MMIO (LED reg, cycle counter) and error reporting.
// - Replaces the bare combinational-read dm; a CPU stalls on cpu_ready.

---
 rtl/mem_bus_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mem_bus_ctrl.sv
// Data-memory controller: req/ready handshake with wait states, byte/half/word lanes, LED + cycle-counter MMIO.
// Optional request/error statistics registers at MMIO +8/+12 when MEM_BUS_STATS_EN is defined.
module mem_bus_ctrl #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF0000,
  parameter int unsigned LED_W       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  input  logic [2:0]       cpu_dmtype,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_ready,
  output logic             cpu_err,
  output logic [LED_W-1:0] led_out
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
  localparam logic [3:0]  WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state_q, state_d;

  logic [3:0]       wcnt_q, wcnt_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic [2:0]       dmt_q, dmt_d;
  logic [31:0]      rdata_q, rdata_d, cyc_q, cyc_d;
  logic             err_q, err_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      ram_q [DEPTH];

`ifdef MEM_BUS_STATS_EN
  logic [31:0] req_cnt_q, req_cnt_d, err_cnt_q, err_cnt_d;
`endif

  // With zero wait states the access edge is the accept edge, so decode live inputs while idle.
  logic        in_idle, access, acc_we, acc_err, ram_hit, mmio_sel, mmio_ok, ram_we;
  logic        is_word, is_half, is_byte, sgn, bad_type, misalign;
  logic [31:0] acc_addr, acc_wdata, ram_word, lane, load_val, mmio_rd, wshift;
  logic [2:0]  acc_dmt;
  logic [3:0]  be;
  logic [AW-1:0] ram_idx;

  assign in_idle   = (state_q == S_IDLE);
  assign acc_we    = in_idle ? cpu_we     : we_q;
  assign acc_addr  = in_idle ? cpu_addr   : addr_q;
  assign acc_wdata = in_idle ? cpu_wdata  : wdata_q;
  assign acc_dmt   = in_idle ? cpu_dmtype : dmt_q;
  assign access    = (state_d == S_RESP) && (state_q != S_RESP);

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: if (cpu_req) begin
        state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        wcnt_d  = 4'd0;
      end
      S_WAIT: if (wcnt_q == WAIT_LAST) state_d = S_RESP;
              else                     wcnt_d  = wcnt_q + 4'd1;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    we_d = we_q; addr_d = addr_q; wdata_d = wdata_q; dmt_d = dmt_q;
    if (in_idle && cpu_req) begin
      we_d = cpu_we; addr_d = cpu_addr; wdata_d = cpu_wdata; dmt_d = cpu_dmtype;
    end
  end

  always_comb begin
    is_word  = (acc_dmt == 3'b000);
    is_half  = (acc_dmt == 3'b001) || (acc_dmt == 3'b010);
    is_byte  = (acc_dmt == 3'b011) || (acc_dmt == 3'b100);
    sgn      = (acc_dmt == 3'b001) || (acc_dmt == 3'b011);
    bad_type = (acc_dmt > 3'b100);
    misalign = (is_half && acc_addr[0]) || (is_word && (acc_addr[1:0] != 2'b00));
    ram_hit  = (acc_addr < RAM_BYTES);
    mmio_sel = !ram_hit && (acc_addr[31:4] == MMIO_BASE[31:4]);
    ram_idx  = acc_addr[AW+1:2];
    ram_word = ram_q[ram_idx];
    mmio_rd  = 32'd0;
    mmio_ok  = 1'b0;
    case (acc_addr[3:2])
      2'd0: begin mmio_rd = 32'(led_q); mmio_ok = 1'b1;    end
      2'd1: begin mmio_rd = cyc_q;      mmio_ok = !acc_we; end
`ifdef MEM_BUS_STATS_EN
      2'd2: begin mmio_rd = req_cnt_q;  mmio_ok = !acc_we; end
      2'd3: begin mmio_rd = err_cnt_q;  mmio_ok = !acc_we; end
`endif
      default: ;
    endcase
    acc_err = bad_type || misalign || !(ram_hit || (mmio_sel && is_word && mmio_ok));

    lane = ram_word >> {acc_addr[1:0], 3'b000};
    if (is_half)      load_val = {{16{sgn & lane[15]}}, lane[15:0]};
    else if (is_byte) load_val = {{24{sgn & lane[7]}}, lane[7:0]};
    else              load_val = ram_word;
    if (mmio_sel) load_val = mmio_rd;

    if (is_word)      be = 4'b1111;
    else if (is_half) be = 4'b0011 << {acc_addr[1], 1'b0};
    else              be = 4'b0001 << acc_addr[1:0];
    wshift = acc_wdata << {acc_addr[1:0], 3'b000};
    ram_we = access && !acc_err && acc_we && ram_hit;
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    led_d   = led_q;
    cyc_d   = cyc_q + 32'd1;
    if (access) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_we) ? 32'd0 : load_val;
      if (!acc_err && acc_we && mmio_sel && (acc_addr[3:2] == 2'd0))
        led_d = acc_wdata[LED_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wcnt_q <= 4'd0; we_q <= 1'b0; addr_q <= 32'd0; wdata_q <= 32'd0; dmt_q <= 3'd0;
      rdata_q <= 32'd0; err_q <= 1'b0; led_q <= '0; cyc_q <= 32'd0;
    end else begin
      wcnt_q <= wcnt_d; we_q <= we_d; addr_q <= addr_d; wdata_q <= wdata_d; dmt_q <= dmt_d;
      rdata_q <= rdata_d; err_q <= err_d; led_q <= led_d; cyc_q <= cyc_d;
    end
  end

  // RAM is never cleared; reset only blocks a store landing on the same edge.
  always_ff @(posedge clk) begin
    if (rstn && ram_we) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) ram_q[ram_idx][8*i +: 8] <= wshift[8*i +: 8];
    end
  end

`ifdef MEM_BUS_STATS_EN
  always_comb begin
    req_cnt_d = req_cnt_q;
    err_cnt_d = err_cnt_q;
    if (state_q == S_RESP) begin
      req_cnt_d = req_cnt_q + 32'd1;
      if (err_q) err_cnt_d = err_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      req_cnt_q <= 32'd0;
      err_cnt_q <= 32'd0;
    end else begin
      req_cnt_q <= req_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end
`endif

  always_comb begin
    cpu_ready = (state_q == S_RESP);
    cpu_err   = err_q;
    cpu_rdata = rdata_q;
    led_out   = led_q;
  end
endmodule
